// File: rtl/decode_fwd_regfile_if.sv
// Decode-stage bundle: D register, forwarding sources, E-register control and outputs.
interface decode_fwd_regfile_if #(
    parameter int DATA_W = 64,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 16
);
    logic [3:0]        D_icode;
    logic [3:0]        D_ifun;
    logic [RA_W-1:0]   D_rA;
    logic [RA_W-1:0]   D_rB;
    logic [3:0]        D_Stat;
    logic [DATA_W-1:0] D_valC;
    logic [DATA_W-1:0] D_valP;
    logic [RA_W-1:0]   e_dstE;
    logic [DATA_W-1:0] e_valE;
    logic [RA_W-1:0]   M_dstE;
    logic [DATA_W-1:0] M_valE;
    logic [RA_W-1:0]   M_dstM;
    logic [DATA_W-1:0] m_valM;
    logic [RA_W-1:0]   W_dstE;
    logic [DATA_W-1:0] W_valE;
    logic [RA_W-1:0]   W_dstM;
    logic [DATA_W-1:0] W_valM;
    logic              E_stall;
    logic              E_bubble;
    logic [3:0]        q_icode;
    logic [3:0]        q_ifun;
    logic [DATA_W-1:0] q_valA;
    logic [DATA_W-1:0] q_valB;
    logic [DATA_W-1:0] q_valC;
    logic [3:0]        q_Stat;
    logic [RA_W-1:0]   q_dstE;
    logic [RA_W-1:0]   q_dstM;
    logic [RA_W-1:0]   q_srcA;
    logic [RA_W-1:0]   q_srcB;
    logic              d_stall;
    logic [CNT_W-1:0]  fwd_cnt;

    modport slave (
        input  D_icode, D_ifun, D_rA, D_rB, D_Stat, D_valC, D_valP,
        input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        input  W_dstE, W_valE, W_dstM, W_valM, E_stall, E_bubble,
        output q_icode, q_ifun, q_valA, q_valB, q_valC, q_Stat,
        output q_dstE, q_dstM, q_srcA, q_srcB, d_stall, fwd_cnt
    );

    modport master (
        output D_icode, D_ifun, D_rA, D_rB, D_Stat, D_valC, D_valP,
        output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        output W_dstE, W_valE, W_dstM, W_valM, E_stall, E_bubble,
        input  q_icode, q_ifun, q_valA, q_valB, q_valC, q_Stat,
        input  q_dstE, q_dstM, q_srcA, q_srcB, d_stall, fwd_cnt
    );
endinterface

// File: rtl/decode_fwd_regfile.sv
// Y86-style decode stage: register file, operand forwarding, load-use/RAW stall
// detection and the E pipeline register.
module decode_fwd_regfile #(
    parameter int DATA_W  = 64,
    parameter int NREGS   = 16,
    parameter int SP_INIT = 2047,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    decode_fwd_regfile_if.slave  bus
);
    localparam int RA_W = $clog2(NREGS);
    localparam logic [RA_W-1:0]   RNONE  = RA_W'(NREGS - 1);
    localparam logic [RA_W-1:0]   RSP    = RA_W'(4);
    localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [DATA_W-1:0] regs [NREGS];
    logic [RA_W-1:0]   src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
    logic              fwd_a, fwd_b;
    logic              load_use, raw_hit;
    logic              e_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == 4) ? SP_VAL : '0;
        end else begin
            if (bus.W_dstE != RNONE) regs[bus.W_dstE] <= bus.W_valE;
            if (bus.W_dstM != RNONE) regs[bus.W_dstM] <= bus.W_valM;
        end
    end

    always_comb begin
        src_a = bus.D_rA;
        src_b = bus.D_rB;
        dst_e = bus.D_rB;
        dst_m = RNONE;
        case (bus.D_icode)
            I_IRMOVQ: src_a = RNONE;
            I_CALL, I_RET, I_POPQ: src_a = RSP;
            default: ;
        endcase
        if (bus.D_icode == I_PUSHQ || bus.D_icode == I_CALL ||
            bus.D_icode == I_RET   || bus.D_icode == I_POPQ) begin
            src_b = RSP;
            dst_e = RSP;
        end else if (bus.D_icode == I_MRMOVQ) begin
            dst_e = RNONE;
        end
        if (bus.D_icode == I_RET || bus.D_icode == I_POPQ) dst_m = bus.D_rA;
        else if (bus.D_icode == I_MRMOVQ)                  dst_m = bus.D_rB;
    end

    // RNONE is never stored, so its read port is tied to zero.
    assign rf_a = (src_a == RNONE) ? '0 : regs[src_a];
    assign rf_b = (src_b == RNONE) ? '0 : regs[src_b];

    always_comb begin
        val_a = rf_a;
        fwd_a = 1'b0;
        if (bus.D_icode == I_CALL || bus.D_icode == I_JXX) begin
            val_a = bus.D_valP;
        end else if (FWD_EN != 0 && src_a != RNONE) begin
            fwd_a = 1'b1;
            if      (src_a == bus.e_dstE) val_a = bus.e_valE;
            else if (src_a == bus.M_dstM) val_a = bus.m_valM;
            else if (src_a == bus.M_dstE) val_a = bus.M_valE;
            else if (src_a == bus.W_dstM) val_a = bus.W_valM;
            else if (src_a == bus.W_dstE) val_a = bus.W_valE;
            else                          fwd_a = 1'b0;
        end
    end

    always_comb begin
        val_b = rf_b;
        fwd_b = 1'b0;
        if (FWD_EN != 0 && src_b != RNONE) begin
            fwd_b = 1'b1;
            if      (src_b == bus.e_dstE) val_b = bus.e_valE;
            else if (src_b == bus.M_dstM) val_b = bus.m_valM;
            else if (src_b == bus.M_dstE) val_b = bus.M_valE;
            else if (src_b == bus.W_dstM) val_b = bus.W_valM;
            else if (src_b == bus.W_dstE) val_b = bus.W_valE;
            else                          fwd_b = 1'b0;
        end
    end

    function automatic logic pending(input logic [RA_W-1:0] s);
        return (s != RNONE) &&
               (s == bus.e_dstE || s == bus.M_dstE || s == bus.M_dstM ||
                s == bus.W_dstE || s == bus.W_dstM);
    endfunction

    always_comb begin
        load_use = (bus.q_icode == I_MRMOVQ || bus.q_icode == I_POPQ) &&
                   (bus.q_dstM != RNONE) &&
                   (bus.q_dstM == src_a || bus.q_dstM == src_b);
        raw_hit  = (FWD_EN == 0) && (pending(src_a) || pending(src_b));
    end

    assign bus.d_stall = load_use || raw_hit;
    assign e_load      = !bus.E_bubble && !bus.E_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.E_bubble) begin
            if (!rst_n) bus.fwd_cnt <= '0;
            bus.q_icode <= I_NOP;
            bus.q_ifun  <= 4'h0;
            bus.q_Stat  <= 4'h1;
            bus.q_valA  <= '0;
            bus.q_valB  <= '0;
            bus.q_valC  <= '0;
            bus.q_dstE  <= RNONE;
            bus.q_dstM  <= RNONE;
            bus.q_srcA  <= RNONE;
            bus.q_srcB  <= RNONE;
        end else if (e_load) begin
            bus.q_icode <= bus.D_icode;
            bus.q_ifun  <= bus.D_ifun;
            bus.q_Stat  <= bus.D_Stat;
            bus.q_valA  <= val_a;
            bus.q_valB  <= val_b;
            bus.q_valC  <= bus.D_valC;
            bus.q_dstE  <= dst_e;
            bus.q_dstM  <= dst_m;
            bus.q_srcA  <= src_a;
            bus.q_srcB  <= src_b;
            if ((fwd_a || fwd_b) && bus.fwd_cnt != '1)
                bus.fwd_cnt <= bus.fwd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_fwd_regfile.sv
// Directed bench: forwarding instance (narrow counter for saturation) and a
// no-forwarding instance for RAW stalls and mid-run reset.
module tb_decode_fwd_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_nf = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decode_fwd_regfile_if #(.DATA_W(64), .RA_W(4), .CNT_W(4))  bus_f ();
    decode_fwd_regfile_if #(.DATA_W(64), .RA_W(4), .CNT_W(16)) bus_n ();

    decode_fwd_regfile #(.DATA_W(64), .NREGS(16), .SP_INIT(2047), .FWD_EN(1), .CNT_W(4))
        u_fwd (.clk(clk), .rst_n(rst_n), .bus(bus_f));
    decode_fwd_regfile #(.DATA_W(64), .NREGS(16), .SP_INIT(2047), .FWD_EN(0), .CNT_W(16))
        u_nf (.clk(clk), .rst_n(rst_nf), .bus(bus_n));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_f();
        bus_f.e_dstE = 4'hF; bus_f.e_valE = '0;
        bus_f.M_dstE = 4'hF; bus_f.M_valE = '0;
        bus_f.M_dstM = 4'hF; bus_f.m_valM = '0;
        bus_f.W_dstE = 4'hF; bus_f.W_valE = '0;
        bus_f.W_dstM = 4'hF; bus_f.W_valM = '0;
        bus_f.E_stall = 1'b0; bus_f.E_bubble = 1'b0;
    endtask

    task automatic dec_f(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        bus_f.D_icode = ic; bus_f.D_ifun = 4'h0; bus_f.D_rA = ra; bus_f.D_rB = rb;
        bus_f.D_Stat = 4'h1; bus_f.D_valC = 64'h0; bus_f.D_valP = 64'h0;
    endtask

    task automatic clr_n();
        bus_n.e_dstE = 4'hF; bus_n.e_valE = '0;
        bus_n.M_dstE = 4'hF; bus_n.M_valE = '0;
        bus_n.M_dstM = 4'hF; bus_n.m_valM = '0;
        bus_n.W_dstE = 4'hF; bus_n.W_valE = '0;
        bus_n.W_dstM = 4'hF; bus_n.W_valM = '0;
        bus_n.E_stall = 1'b0; bus_n.E_bubble = 1'b0;
    endtask

    task automatic dec_n(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        bus_n.D_icode = ic; bus_n.D_ifun = 4'h0; bus_n.D_rA = ra; bus_n.D_rB = rb;
        bus_n.D_Stat = 4'h1; bus_n.D_valC = 64'h0; bus_n.D_valP = 64'h0;
    endtask

    initial begin
        clr_f(); dec_f(4'h1, 4'hF, 4'hF);
        clr_n(); dec_n(4'h1, 4'hF, 4'hF);
        #12;
        chk("rst_icode", bus_f.q_icode, 4'h1);
        chk("rst_stat",  bus_f.q_Stat,  4'h1);
        chk("rst_dstE",  bus_f.q_dstE,  4'hF);
        chk("rst_cnt",   bus_f.fwd_cnt, 4'h0);

        rst_n = 1'b1;
        dec_f(4'h2, 4'h4, 4'h0);
        tick();
        chk("rrmov_valA", bus_f.q_valA, 64'd2047);
        chk("rrmov_valB", bus_f.q_valB, 64'd0);
        chk("rrmov_dstE", bus_f.q_dstE, 4'h0);
        chk("rrmov_srcA", bus_f.q_srcA, 4'h4);
        chk("rrmov_cnt",  bus_f.fwd_cnt, 4'd0);

        bus_f.e_dstE = 4'h3; bus_f.e_valE = 64'h55;
        bus_f.M_dstE = 4'h3; bus_f.M_valE = 64'h66;
        dec_f(4'h6, 4'h3, 4'h7);
        tick();
        chk("exe_prio_valA", bus_f.q_valA, 64'h55);
        chk("exe_prio_valB", bus_f.q_valB, 64'h0);
        chk("exe_prio_cnt",  bus_f.fwd_cnt, 4'd1);

        clr_f();
        bus_f.W_dstE = 4'h6; bus_f.W_valE = 64'h1;
        bus_f.W_dstM = 4'h6; bus_f.W_valM = 64'h2;
        dec_f(4'h1, 4'hF, 4'hF);
        tick();
        clr_f();
        dec_f(4'h6, 4'h6, 4'hF);
        tick();
        chk("wr_dstM_wins", bus_f.q_valA, 64'h2);
        chk("wr_cnt",       bus_f.fwd_cnt, 4'd1);

        bus_f.M_dstM = 4'h2; bus_f.m_valM = 64'h77;
        bus_f.M_dstE = 4'h2; bus_f.M_valE = 64'h88;
        dec_f(4'h2, 4'h2, 4'hF);
        tick();
        chk("mdstM_prio", bus_f.q_valA, 64'h77);
        chk("mdstM_cnt",  bus_f.fwd_cnt, 4'd2);

        clr_f();
        bus_f.W_dstE = 4'h9; bus_f.W_valE = 64'h99;
        dec_f(4'h6, 4'hF, 4'h9);
        tick();
        chk("wE_valB",   bus_f.q_valB, 64'h99);
        chk("rnone_rd0", bus_f.q_valA, 64'h0);
        chk("wE_cnt",    bus_f.fwd_cnt, 4'd3);

        clr_f();
        dec_f(4'h8, 4'h0, 4'h0);
        bus_f.D_valP = 64'h123;
        tick();
        chk("call_valA", bus_f.q_valA, 64'h123);
        chk("call_valB", bus_f.q_valB, 64'd2047);
        chk("call_srcA", bus_f.q_srcA, 4'h4);
        chk("call_dstE", bus_f.q_dstE, 4'h4);
        chk("call_cnt",  bus_f.fwd_cnt, 4'd3);

        dec_f(4'hB, 4'h3, 4'h0);
        tick();
        chk("pop_dstM", bus_f.q_dstM, 4'h3);
        chk("pop_dstE", bus_f.q_dstE, 4'h4);
        chk("pop_srcB", bus_f.q_srcB, 4'h4);

        dec_f(4'h5, 4'hF, 4'h2);
        bus_f.D_valC = 64'h10;
        tick();
        chk("mrm_icode", bus_f.q_icode, 4'h5);
        chk("mrm_dstM",  bus_f.q_dstM,  4'h2);
        chk("mrm_dstE",  bus_f.q_dstE,  4'hF);
        chk("mrm_valC",  bus_f.q_valC,  64'h10);
        dec_f(4'h6, 4'h2, 4'hF);
        #1;
        chk("load_use_stall", bus_f.d_stall, 1'b1);
        bus_f.E_bubble = 1'b1;
        tick();
        chk("bubble_icode", bus_f.q_icode, 4'h1);
        chk("bubble_dstE",  bus_f.q_dstE,  4'hF);
        chk("bubble_stat",  bus_f.q_Stat,  4'h1);
        chk("post_bubble_nostall", bus_f.d_stall, 1'b0);

        clr_f();
        bus_f.E_stall = 1'b1;
        bus_f.e_dstE = 4'h3; bus_f.e_valE = 64'h5;
        dec_f(4'h6, 4'h3, 4'h3);
        tick();
        chk("stall_hold_icode", bus_f.q_icode, 4'h1);
        chk("stall_hold_cnt",   bus_f.fwd_cnt, 4'd3);
        bus_f.E_stall = 1'b0;
        tick();
        chk("unstall_icode", bus_f.q_icode, 4'h6);
        chk("unstall_cnt",   bus_f.fwd_cnt, 4'd4);
        bus_f.E_stall = 1'b1; bus_f.E_bubble = 1'b1;
        tick();
        chk("bub_over_stall", bus_f.q_icode, 4'h1);
        chk("bub_over_stall_valA", bus_f.q_valA, 64'h0);

        bus_f.E_stall = 1'b0; bus_f.E_bubble = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_saturate", bus_f.fwd_cnt, 4'hF);

        rst_nf = 1'b1;
        clr_n();
        bus_n.M_dstE = 4'h5; bus_n.M_valE = 64'h5A;
        dec_n(4'h6, 4'hF, 4'h5);
        #1;
        chk("nf_raw_stall", bus_n.d_stall, 1'b1);
        tick();
        chk("nf_no_fwd_valB", bus_n.q_valB, 64'h0);
        chk("nf_srcB",        bus_n.q_srcB, 4'h5);
        chk("nf_cnt",         bus_n.fwd_cnt, 16'd0);
        clr_n();
        #1;
        chk("nf_no_stall", bus_n.d_stall, 1'b0);
        bus_n.W_dstE = 4'h4; bus_n.W_valE = 64'h1234;
        #1;
        chk("nf_W_stall", bus_n.d_stall, 1'b0);
        tick();
        chk("nf_reg4_wr", u_nf.regs[4], 64'h1234);
        #2;
        rst_nf = 1'b0;
        #1;
        chk("nf_rst_reg4",  u_nf.regs[4], 64'd2047);
        chk("nf_rst_srcB",  bus_n.q_srcB, 4'hF);
        chk("nf_rst_icode", bus_n.q_icode, 4'h1);
        tick();
        chk("nf_rst_held", bus_n.q_srcB, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
